// File: rtl/hack_pkg.sv
// hack_pkg: shared HACK CPU widths, fetch FSM state encoding and reset PC.
package hack_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] PC_RESET = '0;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;
endpackage

// File: rtl/hack_fetch_if.sv
// hack_fetch_if: instruction ROM req/ack bus, instruction valid/ready stream and redirect/halt controls.
interface hack_fetch_if #(
    parameter int ADDR_W = hack_pkg::ADDR_W,
    parameter int DATA_W = hack_pkg::DATA_W
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;

    modport master (
        output rom_req, rom_addr, inst_valid, inst, inst_pc,
        input  rom_ack, rom_data, inst_ready, jump_en, jump_addr, halt
    );

    modport slave (
        input  rom_req, rom_addr, inst_valid, inst, inst_pc,
        output rom_ack, rom_data, inst_ready, jump_en, jump_addr, halt
    );
endinterface

// File: rtl/hack_pc.sv
// hack_pc: program counter register with load (priority) and wrapping increment.
module hack_pc #(
    parameter int ADDR_W = hack_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= ADDR_W'(hack_pkg::PC_RESET);
        else if (load)
            pc <= load_addr;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end
endmodule

// File: rtl/hack_fetch.sv
// hack_fetch: HACK CPU fetch stage; one ROM read in flight, registered instruction hand-off,
// jump redirects that flush held or in-flight instructions, and halt that never drops data.
module hack_fetch #(
    parameter int ADDR_W = hack_pkg::ADDR_W,
    parameter int DATA_W = hack_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    hack_fetch_if.master bus
);
    import hack_pkg::*;

    fetch_state_t      state, state_d;
    logic              req_d, valid_d, pend, pend_d, pc_load, pc_inc;
    logic [ADDR_W-1:0] addr_d, ipc_d, raddr, raddr_d, pc, pc_val;
    logic [DATA_W-1:0] inst_d;

    hack_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_addr (pc_val),
        .pc        (pc)
    );

    // pc always equals rom_addr while in REQ, so a good ack just increments it
    always_comb begin
        state_d = state;
        req_d   = bus.rom_req;
        addr_d  = bus.rom_addr;
        valid_d = bus.inst_valid;
        inst_d  = bus.inst;
        ipc_d   = bus.inst_pc;
        pend_d  = pend;
        raddr_d = raddr;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        pc_val  = bus.jump_addr;
        unique case (state)
            IDLE: begin
                pc_load = bus.jump_en;
                if (!bus.halt) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = bus.jump_en ? bus.jump_addr : pc;
                end
            end
            REQ: begin
                if (bus.rom_ack && (pend || bus.jump_en)) begin
                    pc_load = 1'b1;
                    pc_val  = bus.jump_en ? bus.jump_addr : raddr;
                    pend_d  = 1'b0;
                    state_d = bus.halt ? IDLE : REQ;
                    req_d   = !bus.halt;
                    addr_d  = pc_val;
                end else if (bus.rom_ack) begin
                    pc_inc  = 1'b1;
                    inst_d  = bus.rom_data;
                    ipc_d   = bus.rom_addr;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else if (bus.jump_en) begin
                    pend_d  = 1'b1;
                    raddr_d = bus.jump_addr;
                end
            end
            HOLD: begin
                if (bus.jump_en || bus.inst_ready) begin
                    pc_load = bus.jump_en;
                    valid_d = 1'b0;
                    state_d = bus.halt ? IDLE : REQ;
                    req_d   = !bus.halt;
                    addr_d  = bus.jump_en ? bus.jump_addr : pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.rom_req    <= 1'b0;
            bus.rom_addr   <= ADDR_W'(PC_RESET);
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
            pend           <= 1'b0;
            raddr          <= '0;
        end else begin
            state          <= state_d;
            bus.rom_req    <= req_d;
            bus.rom_addr   <= addr_d;
            bus.inst_valid <= valid_d;
            bus.inst       <= inst_d;
            bus.inst_pc    <= ipc_d;
            pend           <= pend_d;
            raddr          <= raddr_d;
        end
    end
endmodule

// File: tb/tb_hack_fetch.sv
// tb_hack_fetch: directed scenarios plus randomized traffic, checked by a queue scoreboard
// fed from an address-level model of the fetch rules.
module tb_hack_fetch;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int PH_PLAIN = 0, PH_STALL = 1, PH_JUMP = 2, PH_WRAP = 3, PH_RAND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hack_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    hack_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } item_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    item_t exp_q[$];
    logic [AW-1:0] got_pc[$];
    int got_cyc[$];

    logic [AW-1:0] next_fetch, cur_addr, pend_addr, p_addr;
    logic pend, p_req, p_ack, p_halt, wrap_ack, rand_halt;
    int wait_cnt, lat, lat_mode, phase, stall_cnt, halt_ticks, halt_rel;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = DW'(a);
        return (w * 16'hA3C5) ^ 16'h1F2E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // monitor: every presented instruction must match the scoreboard head
    always @(negedge clk) begin
        if (bus.inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_inst got_pc=%0h exp=none t=%0t", bus.inst_pc, $time);
            end else begin
                chk("inst_pc", 32'(bus.inst_pc), 32'(exp_q[0].pc));
                chk("inst", 32'(bus.inst), 32'(exp_q[0].inst));
                if (bus.inst_ready) begin
                    void'(exp_q.pop_front());
                    got_pc.push_back(bus.inst_pc);
                    got_cyc.push_back(cyc);
                end else if (bus.jump_en) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        got_pc.delete();
        got_cyc.delete();
        next_fetch = '0;
        pend = 1'b0;
        pend_addr = '0;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_halt = 1'b0;
        p_addr = '0;
        wait_cnt = 0;
        lat = 0;
    endtask

    task automatic tick();
        logic ack;
        item_t it;
        @(posedge clk);
        #1;
        if (bus.rom_req && (!p_req || p_ack)) begin
            chk("rom_addr", 32'(bus.rom_addr), 32'(next_fetch));
            cur_addr = next_fetch;
            wait_cnt = 0;
            lat = lat_mode < 0 ? int'($urandom_range(0, 3)) : lat_mode;
        end else if (bus.rom_req) begin
            chk("rom_addr_stable", 32'(bus.rom_addr), 32'(p_addr));
            wait_cnt++;
        end
        if (p_halt && bus.rom_req)
            chk("halt_no_new_req", {30'd0, p_req, p_ack}, 32'b10);
        ack = bus.rom_req && wait_cnt >= lat;
        bus.rom_ack = ack;
        bus.rom_data = ack ? rom_f(bus.rom_addr) : DW'($urandom);
        bus.inst_ready = 1'b1;
        bus.jump_en = 1'b0;
        bus.jump_addr = AW'($urandom);
        bus.halt = 1'b0;
        case (phase)
            PH_STALL: if (bus.inst_valid && bus.inst_pc == 15'd4 && stall_cnt < 5) begin
                bus.inst_ready = 1'b0;
                stall_cnt++;
                chk("stall_no_req", 32'(bus.rom_req), 32'd0);
            end
            PH_JUMP: begin
                if (bus.rom_req && bus.rom_addr == 15'd7 && wait_cnt < 2) begin
                    bus.jump_en = 1'b1;
                    bus.jump_addr = wait_cnt == 0 ? 15'h0100 : 15'h0200;
                end
                if (bus.inst_valid && (bus.inst_pc == 15'h0200 || bus.inst_pc == 15'd9)) begin
                    bus.jump_en = 1'b1;
                    bus.jump_addr = bus.inst_pc == 15'd9 ? 15'h0040 : 15'h0008;
                end
            end
            PH_WRAP: begin
                if (bus.inst_valid && bus.inst_pc == 15'h0041) begin
                    bus.jump_en = 1'b1;
                    bus.jump_addr = 15'h7FFF;
                end
                if (wrap_ack && halt_ticks < 8) begin
                    bus.halt = 1'b1;
                    bus.inst_ready = halt_ticks >= 3;
                    if (halt_ticks >= 4) chk("halt_idle", 32'(bus.rom_req), 32'd0);
                    halt_ticks++;
                    if (halt_ticks == 8) halt_rel = cyc;
                end
            end
            PH_RAND: begin
                bus.inst_ready = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 11) == 0) begin
                    bus.jump_en = 1'b1;
                    bus.jump_addr = $urandom_range(0, 7) == 0 ? 15'h7FFF : AW'($urandom);
                end
                if ($urandom_range(0, 24) == 0) rand_halt = ~rand_halt;
                bus.halt = rand_halt;
            end
            default: ;
        endcase
        if (ack) bus.jump_en = 1'b0;
        // reference model: what the coming edge does to the fetch stream
        if (ack && pend) begin
            next_fetch = pend_addr;
            pend = 1'b0;
        end else if (ack) begin
            it.pc = cur_addr;
            it.inst = rom_f(cur_addr);
            exp_q.push_back(it);
            next_fetch = cur_addr + 1'b1;
            if (phase == PH_WRAP && cur_addr == 15'h7FFF) wrap_ack = 1'b1;
        end else if (bus.jump_en && bus.rom_req) begin
            pend = 1'b1;
            pend_addr = bus.jump_addr;
        end else if (bus.jump_en) begin
            next_fetch = bus.jump_addr;
        end
        p_req = bus.rom_req;
        p_ack = ack;
        p_addr = bus.rom_addr;
        p_halt = bus.halt;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (got_pc.size() < n) begin
            failures++;
            $display("FAIL timeout_%s delivered=%0d need=%0d", name, got_pc.size(), n);
        end
    endtask

    function automatic logic [AW-1:0] got_at(input int i);
        return i < got_pc.size() ? got_pc[i] : 15'h7ABC;
    endfunction

    initial begin
        int base, nine;
        bus.rom_ack = 1'b0;
        bus.rom_data = '0;
        bus.inst_ready = 1'b0;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        bus.halt = 1'b0;
        phase = PH_PLAIN;
        lat_mode = 1;
        stall_cnt = 0;
        halt_ticks = 0;
        halt_rel = 0;
        wrap_ack = 1'b0;
        rand_halt = 1'b0;
        cur_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_req", 32'(bus.rom_req), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", 32'(bus.inst), 32'd0);
        chk("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_until(4, 40, "free");
        for (int i = 0; i < 4; i++) chk("free_seq", 32'(got_at(i)), i);

        phase = PH_STALL;
        run_until(6, 60, "stall");
        chk("stall_pc4", 32'(got_at(4)), 32'd4);
        chk("stall_pc5", 32'(got_at(5)), 32'd5);
        chk("stall_cycles", stall_cnt, 32'd5);

        phase = PH_JUMP;
        lat_mode = 3;
        run_until(11, 150, "jump");
        chk("jreq_pc6", 32'(got_at(6)), 32'd6);
        chk("jreq_target", 32'(got_at(7)), 32'h200);
        chk("jhold_pc8", 32'(got_at(8)), 32'd8);
        chk("jhold_pc9", 32'(got_at(9)), 32'd9);
        chk("jhold_target", 32'(got_at(10)), 32'h40);
        nine = 0;
        foreach (got_pc[i]) if (got_pc[i] == 15'd9 || got_pc[i] == 15'd7) nine++;
        chk("pc9_once_pc7_never", nine, 32'd1);

        phase = PH_WRAP;
        lat_mode = 1;
        run_until(14, 120, "wrap");
        chk("wrap_pc41", 32'(got_at(11)), 32'h41);
        chk("wrap_7fff", 32'(got_at(12)), 32'h7FFF);
        chk("wrap_zero", 32'(got_at(13)), 32'h0);
        chk("wrap_after_halt", 32'(got_cyc.size() > 13 && got_cyc[13] > halt_rel), 32'd1);

        phase = PH_PLAIN;
        lat_mode = 3;
        for (int k = 0; k < 20 && !(bus.rom_req && wait_cnt == 0); k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_req", 32'(bus.rom_req), 32'd0);
        chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
        bus.rom_ack = 1'b1;
        bus.rom_data = 16'hDEAD;
        @(posedge clk);
        #1;
        chk("arst_late_ack_req", 32'(bus.rom_req), 32'd0);
        chk("arst_late_ack_valid", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        bus.rom_ack = 1'b0;
        model_reset();
        rst_n = 1'b1;
        lat_mode = 1;
        run_until(2, 40, "restart");
        chk("restart_pc0", 32'(got_at(0)), 32'd0);
        chk("restart_pc1", 32'(got_at(1)), 32'd1);

        lat_mode = 0;
        base = got_pc.size();
        run_until(base + 5, 40, "zero_wait");
        for (int i = base + 2; i < base + 5 && i < got_cyc.size(); i++)
            chk("zero_wait_gap", got_cyc[i] - got_cyc[i-1], 32'd2);

        phase = PH_RAND;
        lat_mode = -1;
        base = got_pc.size();
        repeat (3000) tick();
        phase = PH_PLAIN;
        lat_mode = 0;
        run_until(got_pc.size() + 3, 200, "drain");
        chk("rand_progress", 32'(got_pc.size() - base > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
